// File: rtl/spi_master_ctrl.sv
// SPI master engine: programmable SCLK divider, CPOL/CPHA modes, MSB/LSB-first
// full-duplex words and one-hot slave select behind a valid/ready host channel.
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int SLAVES = 4,
  parameter int DIV_W  = 8,
  parameter int SS_W   = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_cpol,
  input  logic              cfg_cpha,
  input  logic              cfg_lsb_first,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SS_W-1:0]   tx_ss,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [SLAVES-1:0] ss_n
);

  localparam int EC_W  = $clog2(2 * DATA_W + 1);
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [EC_W-1:0] LAST_EDGE = EC_W'(2 * DATA_W);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_XFER  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, div_s, div_cnt_r, div_cnt_s;
  logic [EC_W-1:0]    edge_cnt_r, edge_cnt_s, edge_nxt_s;
  logic               cpol_r, cpol_s, cpha_r, cpha_s, lsb_r, lsb_s;
  logic [DATA_W-1:0]  data_r, data_s, rx_sh_r, rx_sh_s, rx_data_s;
  logic [SLAVES-1:0]  ss_n_s;
  logic               sclk_s, mosi_s, rx_valid_s, tx_ready_s, busy_s;
  logic               accept_s, half_end_s, last_edge_s, edge_event_s, sample_s, shift_s;

  // Position in the word of the n-th bit on the wire, for either bit order.
  function automatic logic [IDX_W-1:0] bit_pos(input logic [EC_W-1:0] idx, input logic lsb);
    logic [EC_W-1:0] p;
    if (lsb) p = idx;
    else     p = EC_W'(DATA_W - 1) - idx;
    return p[IDX_W-1:0];
  endfunction

  // Active-low one-hot select; an out-of-range index selects nobody.
  function automatic logic [SLAVES-1:0] ss_decode(input logic [SS_W-1:0] idx);
    logic [SLAVES-1:0] v;
    v = {SLAVES{1'b1}};
    for (int i = 0; i < SLAVES; i++) begin
      if (SS_W'(i) == idx) v[i] = 1'b0;
      else                 v[i] = 1'b1;
    end
    return v;
  endfunction

  assign accept_s     = tx_valid && tx_ready;
  assign half_end_s   = (div_cnt_r == div_r);
  assign last_edge_s  = (edge_cnt_r == LAST_EDGE);
  assign edge_nxt_s   = edge_cnt_r + EC_W'(1);
  // The end of SETUP produces edge 1; XFER produces the remaining edges at its boundaries.
  assign edge_event_s = half_end_s && ((state_r == ST_SETUP) || ((state_r == ST_XFER) && !last_edge_s));
  assign sample_s     = edge_event_s && (edge_nxt_s[0] ^ cpha_r);
  assign shift_s      = edge_event_s && !(edge_nxt_s[0] ^ cpha_r) && (edge_nxt_s != LAST_EDGE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (accept_s) state_s = ST_SETUP; else state_s = ST_IDLE;
      ST_SETUP: if (half_end_s) state_s = ST_XFER; else state_s = ST_SETUP;
      ST_XFER:  if (half_end_s && last_edge_s) state_s = ST_HOLD; else state_s = ST_XFER;
      ST_HOLD:  if (half_end_s) state_s = ST_DONE; else state_s = ST_HOLD;
      ST_DONE:  if (accept_s) state_s = ST_SETUP; else state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    div_cnt_s  = half_end_s ? {DIV_W{1'b0}} : div_cnt_r + DIV_W'(1);
    edge_cnt_s = edge_cnt_r;
    div_s      = div_r;
    cpol_s     = cpol_r;
    cpha_s     = cpha_r;
    lsb_s      = lsb_r;
    data_s     = data_r;
    rx_sh_s    = rx_sh_r;
    rx_data_s  = rx_data;
    sclk_s     = sclk;
    mosi_s     = mosi;
    ss_n_s     = ss_n;
    rx_valid_s = 1'b0;
    tx_ready_s = 1'b0;
    busy_s     = busy;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          div_s      = cfg_div;
          cpol_s     = cfg_cpol;
          cpha_s     = cfg_cpha;
          lsb_s      = cfg_lsb_first;
          data_s     = tx_data;
          rx_sh_s    = {DATA_W{1'b0}};
          div_cnt_s  = {DIV_W{1'b0}};
          edge_cnt_s = {EC_W{1'b0}};
          sclk_s     = cfg_cpol;
          mosi_s     = cfg_cpha ? 1'b0 : tx_data[bit_pos(EC_W'(0), cfg_lsb_first)];
          ss_n_s     = ss_decode(tx_ss);
          busy_s     = 1'b1;
        end else begin
          sclk_s     = cfg_cpol;
          mosi_s     = 1'b0;
          ss_n_s     = {SLAVES{1'b1}};
          busy_s     = 1'b0;
          tx_ready_s = 1'b1;
        end
      end
      ST_SETUP, ST_XFER: begin
        if (edge_event_s) begin
          sclk_s     = ~sclk;
          edge_cnt_s = edge_nxt_s;
        end else begin
          sclk_s     = sclk;
        end
        if (sample_s) rx_sh_s[bit_pos(edge_cnt_r >> 1, lsb_r)] = miso;
        else          rx_sh_s = rx_sh_r;
        if (shift_s) mosi_s = data_r[bit_pos(edge_nxt_s >> 1, lsb_r)];
        else         mosi_s = mosi;
      end
      ST_HOLD: begin
        sclk_s = cpol_r;
        if (half_end_s) begin
          ss_n_s     = {SLAVES{1'b1}};
          mosi_s     = 1'b0;
          rx_valid_s = 1'b1;
          rx_data_s  = rx_sh_r;
          tx_ready_s = 1'b1;
          busy_s     = 1'b0;
        end else begin
          busy_s     = 1'b1;
        end
      end
      default: begin
        ss_n_s = {SLAVES{1'b1}};
        busy_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r      <= {DIV_W{1'b0}};
      div_cnt_r  <= {DIV_W{1'b0}};
      edge_cnt_r <= {EC_W{1'b0}};
      cpol_r     <= 1'b0;
      cpha_r     <= 1'b0;
      lsb_r      <= 1'b0;
      data_r     <= {DATA_W{1'b0}};
      rx_sh_r    <= {DATA_W{1'b0}};
      rx_data    <= {DATA_W{1'b0}};
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      ss_n       <= {SLAVES{1'b1}};
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      div_r      <= div_s;
      div_cnt_r  <= div_cnt_s;
      edge_cnt_r <= edge_cnt_s;
      cpol_r     <= cpol_s;
      cpha_r     <= cpha_s;
      lsb_r      <= lsb_s;
      data_r     <= data_s;
      rx_sh_r    <= rx_sh_s;
      rx_data    <= rx_data_s;
      sclk       <= sclk_s;
      mosi       <= mosi_s;
      ss_n       <= ss_n_s;
      rx_valid   <= rx_valid_s;
      tx_ready   <= tx_ready_s;
      busy       <= busy_s;
    end
  end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Parametrised SPI master engine that drives the SPI bus signals defined in the team's SPI interface.
- Adds what the plain interface lacks:
  - a configurable serial clock divider
  - all four CPOL/CPHA modes
  - MSB- or LSB-first shifting
  - DATA_W-bit full-duplex words
  - one-hot selection among SLAVES chip-selects
- The host side uses a valid/ready request channel and a single-cycle response pulse.

Parameters:
- DATA_W, 8: bits per transfer word (>=2).
- SLAVES, 4: number of ss_n pins (>=1).
- DIV_W, 8: width of the clock-divider configuration.
- SS_W, max(1,$clog2(SLAVES)): width of the slave index (derived; do not override).

Ports:
- clk  in  1  system clock; sole clock domain.
- rst  in  1  synchronous, active-high reset.
- cfg_cpol  in  1  SCLK idle level.
- cfg_cpha  in  1  0: sample on leading edge; 1: sample on trailing edge.
- cfg_lsb_first  in  1  1: shift LSB first.
- cfg_div  in  DIV_W  SCLK half-period = cfg_div+1 clk cycles.
- tx_valid  in  1  request valid.
- tx_ready  out  1  engine idle; request is accepted when tx_valid && tx_ready.
- tx_data  in  DATA_W  word to transmit.
- tx_ss  in  SS_W  index of the slave to select.
- rx_valid  out  1  one-cycle pulse; rx_data holds the received word.
- rx_data  out  DATA_W  received word; held until the next rx_valid.
- busy  out  1  high from the accept cycle+1 until the rx_valid cycle, exclusive.
- sclk  out  1  SPI serial clock.
- mosi  out  1  master out.
- miso  in  1  master in; sampled on clk.
- ss_n  out  SLAVES  active-low selects; at most one low ($onehot0 of inverted ss_n).

Behaviour:
- Reset, on the first clk edge with rst=1 and while rst holds:
  - ss_n all ones; sclk=0; mosi=0
  - tx_ready=0, rx_valid=0, rx_data=0, busy=0
  - FSM enters IDLE.
  - The cycle after rst falls: tx_ready=1 and sclk=cfg_cpol.
- Reset mid-transfer aborts the transfer: ss_n all ones at the next edge, no rx_valid, received bits discarded.
- FSM states: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - tx_ready=1; sclk tracks cfg_cpol registered; mosi=0.
  - On accept: latch tx_data, tx_ss and all cfg_* inputs. cfg changes during a transfer have no effect.
- SETUP (one half-period):
  - ss_n[tx_ss]=0.
  - If CPHA=0, mosi is driven with the first bit.
  - If tx_ss>=SLAVES, the transfer runs with ss_n all ones and rx_valid still pulses.
- XFER:
  - 2*DATA_W sclk edges, one every half-period.
  - CPHA=0: sample miso on leading (odd) edges; shift mosi on trailing edges, except after the last edge.
  - CPHA=1: shift mosi on leading edges; sample on trailing edges.
- HOLD (one half-period): sclk at idle level; ss_n still asserted.
- DONE (one cycle):
  - ss_n all ones; rx_valid=1; rx_data updated; tx_ready=1 in this same cycle.
  - A new request can be accepted in the DONE cycle (back-to-back transfers).
- Bit order: cfg_lsb_first selects tx shift direction and rx assembly order identically.
- Latency: accept at cycle 0 -> rx_valid at cycle (2*DATA_W+2)*(cfg_div+1)+1.
  - DATA_W=8, div=0: cycle 19.
  - DATA_W=8, div=3: cycle 73.
- Divider counter reloads at every half-period boundary. cfg_div=max is legal, with no overflow: the counter is DIV_W wide and compares equal to the latched div.
- tx_valid while busy: ignored; tx_ready=0 during the transfer.
- miso is not synchronised in this block; it is sampled at the clk edge that produces the sampling sclk edge.

Test Plan:
- Mode 0, div=0, MSB-first, tx_data=0xA5, tx_ss=2, miso looped from mosi -> ss_n=4'b1011 during transfer, 8 rising sclk edges, rx_valid at cycle 19, rx_data=0xA5.
- All four CPOL/CPHA modes, div=1, slave model returning 0x3C -> sclk idle level equals cpol; rx_data=0x3C each time; mosi captured by the model equals tx_data.
- LSB-first, tx_data=0x01 -> first mosi bit 1 and remaining bits 0; a model sending 0x80 LSB-first yields rx_data=0x80.
- Back-to-back: tx_valid held high with 0x11 then 0x22 -> second accept in the DONE cycle of the first; ss_n deasserted for at least one cycle between the two transfers; no extra rx_valid.
- rst asserted at the 5th sclk edge -> next cycle ss_n=all ones, sclk=0, no rx_valid. A new transfer after reset completes correctly.
- cfg_div changed from 0 to 5 mid-transfer; tx_valid pulsed while busy -> current half-period stays 1 cycle, request ignored, the $onehot0 check on ss_n never fails.
